// File: rtl/turbo_encoder_core_if.sv
// Stream, control and output bundle of turbo_encoder_core.
// The core connects through the slave modport; the driving side uses master.
interface turbo_encoder_core_if #(
    parameter int unsigned KW = 13,
    parameter int unsigned FW = 10
);
    logic          start;
    logic [KW-1:0] blk_len;
    logic          ck1;
    logic          ck1_valid;
    logic          ck1_ready;
    logic          ck2;
    logic          ck2_valid;
    logic          read_request;
    logic          out_valid;
    logic          xk1;
    logic          zk1;
    logic          xk2;
    logic          zk2;
    logic          out_tail;
    logic          out_last;
    logic          busy;
    logic [FW-1:0] fifo_used;
    logic          err_len;

    modport master (
        output start, blk_len, ck1, ck1_valid, ck2, ck2_valid,
        input  ck1_ready, read_request, out_valid, xk1, zk1, xk2, zk2,
               out_tail, out_last, busy, fifo_used, err_len
    );

    modport slave (
        input  start, blk_len, ck1, ck1_valid, ck2, ck2_valid,
        output ck1_ready, read_request, out_valid, xk1, zk1, xk2, zk2,
               out_tail, out_last, busy, fifo_used, err_len
    );
endinterface

// File: rtl/turbo_encoder_core.sv
// Rate-1/3 turbo encoder: two 8-state RSC encoders (fb 1+D^2+D^3, parity 1+D+D^3),
// a skew FIFO on the systematic stream and 12-bit trellis termination.
module turbo_encoder_core #(
    parameter int unsigned KMAX       = 6144,
    parameter int unsigned KMIN       = 40,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned KW         = $clog2(KMAX + 1),
    parameter int unsigned FW         = $clog2(FIFO_DEPTH + 1)
) (
    input logic                clk,
    input logic                aclr,
    turbo_encoder_core_if.slave bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StData, StTail1, StTail2} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
    logic [1:0]    tail_q, tail_d;
    // Encoder state packed as {s1, s2, s3}.
    logic [2:0]    enc1_q, enc1_d, enc2_q, enc2_d;
    logic          valid_q, valid_d, xk1_q, xk1_d, zk1_q, zk1_d;
    logic          xk2_q, xk2_d, zk2_q, zk2_d;
    logic          tail_out_q, tail_out_d, last_q, last_d, err_q, err_d;
    logic          a1, a2;

    logic          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FW-1:0] used_q;
    logic          fifo_full, fifo_empty, push, step, len_ok, head;

    assign fifo_full        = (used_q == FW'(FIFO_DEPTH));
    assign fifo_empty       = (used_q == '0);
    assign push             = bus.ck1_valid && !fifo_full;
    assign bus.read_request = (state_q == StData) && !fifo_empty;
    assign step             = bus.read_request && bus.ck2_valid;
    assign head             = mem[rd_ptr_q];
    assign len_ok           = (bus.blk_len >= KW'(KMIN)) && (bus.blk_len <= KW'(KMAX));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.ck1;
        end
    end

    // Full is evaluated on the pre-pop occupancy, so a full FIFO refuses a write
    // even when the same cycle pops.
    always_ff @(posedge clk) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (step) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, step})
                2'b10:   used_q <= used_q + FW'(1);
                2'b01:   used_q <= used_q - FW'(1);
                default: used_q <= used_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start && len_ok) state_d = StData;
            StData:  if (step && (cnt_q + KW'(1)) == k_q) state_d = StTail1;
            StTail1: if (tail_q == 2'd2) state_d = StTail2;
            StTail2: if (tail_q == 2'd2) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        k_d        = k_q;
        cnt_d      = cnt_q;
        tail_d     = 2'd0;
        enc1_d     = enc1_q;
        enc2_d     = enc2_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        xk1_d      = 1'b0;
        zk1_d      = 1'b0;
        xk2_d      = 1'b0;
        zk2_d      = 1'b0;
        tail_out_d = 1'b0;
        last_d     = 1'b0;
        a1         = head ^ enc1_q[1] ^ enc1_q[0];
        a2         = bus.ck2 ^ enc2_q[1] ^ enc2_q[0];
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (len_ok) begin
                        k_d    = bus.blk_len;
                        cnt_d  = '0;
                        err_d  = 1'b0;
                        enc1_d = '0;
                        enc2_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (step) begin
                    cnt_d   = cnt_q + KW'(1);
                    enc1_d  = {a1, enc1_q[2:1]};
                    enc2_d  = {a2, enc2_q[2:1]};
                    valid_d = 1'b1;
                    xk1_d   = head;
                    zk1_d   = a1 ^ enc1_q[2] ^ enc1_q[0];
                    xk2_d   = bus.ck2;
                    zk2_d   = a2 ^ enc2_q[2] ^ enc2_q[0];
                end
            end
            // Tail input s2^s3 cancels the feedback, shifting a zero into s1.
            StTail1: begin
                tail_d     = (tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1;
                valid_d    = 1'b1;
                tail_out_d = 1'b1;
                xk1_d      = enc1_q[1] ^ enc1_q[0];
                zk1_d      = enc1_q[2] ^ enc1_q[0];
                enc1_d     = {1'b0, enc1_q[2:1]};
            end
            StTail2: begin
                tail_d     = (tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1;
                valid_d    = 1'b1;
                tail_out_d = 1'b1;
                last_d     = (tail_q == 2'd2);
                xk2_d      = enc2_q[1] ^ enc2_q[0];
                zk2_d      = enc2_q[2] ^ enc2_q[0];
                enc2_d     = {1'b0, enc2_q[2:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            k_q        <= '0;
            cnt_q      <= '0;
            tail_q     <= '0;
            enc1_q     <= '0;
            enc2_q     <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            xk1_q      <= 1'b0;
            zk1_q      <= 1'b0;
            xk2_q      <= 1'b0;
            zk2_q      <= 1'b0;
            tail_out_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            tail_q     <= tail_d;
            enc1_q     <= enc1_d;
            enc2_q     <= enc2_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            xk1_q      <= xk1_d;
            zk1_q      <= zk1_d;
            xk2_q      <= xk2_d;
            zk2_q      <= zk2_d;
            tail_out_q <= tail_out_d;
            last_q     <= last_d;
        end
    end

    assign bus.ck1_ready = !fifo_full;
    assign bus.out_valid = valid_q;
    assign bus.xk1       = xk1_q;
    assign bus.zk1       = zk1_q;
    assign bus.xk2       = xk2_q;
    assign bus.zk2       = zk2_q;
    assign bus.out_tail  = tail_out_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.fifo_used = used_q;
    assign bus.err_len   = err_q;
endmodule

// File: tb/tb_turbo_encoder_core.sv
// Randomised bench for turbo_encoder_core against a sequence-level RSC model.
module tb_turbo_encoder_core;
    localparam int KMAX  = 6144;
    localparam int KMIN  = 40;
    localparam int DEPTH = 512;
    localparam int KW    = 13;
    localparam int FW    = 10;

    logic clk = 1'b0;
    logic aclr;
    always #5 clk = ~clk;

    turbo_encoder_core_if #(.KW(KW), .FW(FW)) bus ();

    turbo_encoder_core #(
        .KMAX(KMAX), .KMIN(KMIN), .FIFO_DEPTH(DEPTH), .KW(KW), .FW(FW)
    ) dut (
        .clk (clk),
        .aclr(aclr),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tuple layout: {xk1, zk1, xk2, zk2, out_tail, out_last}
    bit         mon_en = 1'b0;
    logic [5:0] got_q[$];
    int         got_t[$];
    logic [5:0] exp_q[$];
    bit         b1[$];
    bit         b2[$];

    always @(negedge clk) begin
        if (mon_en && bus.out_valid === 1'b1) begin
            got_q.push_back({bus.xk1, bus.zk1, bus.xk2, bus.zk2, bus.out_tail, bus.out_last});
            got_t.push_back(cyc);
        end
    end

    // Each encoder as a feedback sequence a[n] = c ^ a[n-2] ^ a[n-3], parity a[n]^a[n-1]^a[n-3].
    task automatic build_expected(input int k);
        bit h1[$];
        bit h2[$];
        bit z1[$];
        bit z2[$];
        int n;
        bit a;
        h1 = {1'b0, 1'b0, 1'b0};
        h2 = {1'b0, 1'b0, 1'b0};
        for (int i = 0; i < k; i++) begin
            n = h1.size();
            a = b1[i] ^ h1[n-2] ^ h1[n-3];
            z1.push_back(a ^ h1[n-1] ^ h1[n-3]);
            h1.push_back(a);
            n = h2.size();
            a = b2[i] ^ h2[n-2] ^ h2[n-3];
            z2.push_back(a ^ h2[n-1] ^ h2[n-3]);
            h2.push_back(a);
        end
        exp_q.delete();
        for (int i = 0; i < k; i++) exp_q.push_back({b1[i], z1[i], b2[i], z2[i], 2'b00});
        for (int t = 0; t < 3; t++) begin
            n = h1.size();
            exp_q.push_back({h1[n-2] ^ h1[n-3], h1[n-1] ^ h1[n-3], 2'b00, 2'b10});
            h1.push_back(1'b0);
        end
        for (int t = 0; t < 3; t++) begin
            n = h2.size();
            exp_q.push_back({2'b00, h2[n-2] ^ h2[n-3], h2[n-1] ^ h2[n-3], 1'b1, t == 2});
            h2.push_back(1'b0);
        end
    endtask

    task automatic fill_fifo();
        for (int i = 0; i < b1.size(); i++) begin
            bus.ck1_valid = 1'b1;
            bus.ck1       = b1[i];
            @(negedge clk);
        end
        bus.ck1_valid = 1'b0;
    endtask

    task automatic stream(input int k, input int mode, input int abort_at, input int first);
        int idx = first;
        int budget = 0;
        bit tog = 1'b1;
        while (idx < k && budget < 20000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            bus.ck2_valid = (mode == 0) ? 1'b1 : tog;
            tog           = ~tog;
            bus.ck2       = b2[idx];
            if (bus.read_request === 1'b1 && bus.ck2_valid) idx++;
            @(negedge clk);
            budget++;
        end
        bus.ck2_valid = 1'b0;
        if (abort_at < 0) begin
            checks++;
            if (idx != k) begin
                errors++;
                $display("FAIL stream_timeout: consumed %0d of %0d ck2 bits", idx, k);
            end
        end
    endtask

    task automatic wait_idle(output int tf);
        int n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tf = cyc;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, want 0", bus.busy, n);
        end
    endtask

    task automatic run_block(input int k, input int mode, input string name);
        int t0;
        int tf;
        int n;
        int bad = 0;
        fill_fifo();
        got_q.delete();
        got_t.delete();
        mon_en      = 1'b1;
        bus.start   = 1'b1;
        bus.blk_len = KW'(k);
        t0          = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        stream(k, mode, -1, 0);
        wait_idle(tf);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        build_expected(k);
        checks++;
        if (got_q.size() != k + 6) begin
            errors++;
            $display("FAIL %s count: got %0d tuples, want %0d", name, got_q.size(), k + 6);
        end
        n = (got_q.size() < k + 6) ? got_q.size() : k + 6;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s tuple[%0d]: got %b want %b", name, i, got_q[i], exp_q[i]);
            end
        end
        if (got_t.size() == k + 6) begin
            if (mode == 0) begin
                checks++;
                if (got_t[0] != t0 + 2 || got_t[k+5] != t0 + k + 7) begin
                    errors++;
                    $display("FAIL %s timing: first %0d last %0d, want %0d and %0d", name,
                             got_t[0] - t0, got_t[k+5] - t0, 2, k + 7);
                end
                checks++;
                if (tf != t0 + k + 7) begin
                    errors++;
                    $display("FAIL %s busy_fall: cycle %0d, want %0d", name, tf - t0, k + 7);
                end
            end else begin
                for (int i = 1; i < k; i++) if (got_t[i] - got_t[i-1] != 2) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL %s spacing: %0d data gaps not 2 cycles, want 0", name, bad);
                end
            end
        end
    endtask

    task automatic rand_bits(input int k);
        b1.delete();
        b2.delete();
        for (int i = 0; i < k; i++) begin
            b1.push_back(1'($urandom_range(0, 1)));
            b2.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset();
        rand_bits(40);
        bus.ck1_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.start   = 1'b1;
        bus.blk_len = KW'(40);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.ck2_valid = 1'b1;
        repeat (3) @(negedge clk);
        aclr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.xk1, bus.zk1, bus.xk2, bus.zk2, bus.out_tail, bus.out_last,
             bus.busy, bus.err_len, bus.read_request} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b%b%b%b%b%b%b, want all 0", bus.out_valid,
                     bus.xk1, bus.zk1, bus.xk2, bus.zk2, bus.out_tail, bus.out_last, bus.busy,
                     bus.err_len, bus.read_request);
        end
        checks++;
        if (bus.ck1_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ck1_ready: got %b want 1", bus.ck1_ready);
        end
        checks++;
        if (bus.fifo_used !== '0) begin
            errors++;
            $display("FAIL reset_fifo_used: got %0d want 0", bus.fifo_used);
        end
        bus.ck1_valid = 1'b0;
        bus.ck2_valid = 1'b0;
        aclr          = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_block();
        b1.delete();
        b2.delete();
        for (int i = 0; i < 40; i++) begin
            b1.push_back(1'b0);
            b2.push_back(1'b0);
        end
        run_block(40, 0, "zero_block");
    endtask

    task automatic test_impulse();
        bit pat[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        b1.delete();
        b2.delete();
        for (int i = 0; i < 40; i++) begin
            b1.push_back(i == 0);
            b2.push_back(i == 0);
        end
        run_block(40, 0, "impulse");
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i][4] !== pat[i] || got_q[i][2] !== pat[i]) begin
                errors++;
                $display("FAIL impulse_parity[%0d]: got zk1/zk2 %b/%b want %b", i,
                         (got_q.size() > i) ? got_q[i][4] : 1'bx,
                         (got_q.size() > i) ? got_q[i][2] : 1'bx, pat[i]);
            end
        end
        b1.delete();
        b2.delete();
        for (int i = 0; i < 40; i++) begin
            b1.push_back(1'b0);
            b2.push_back(1'b0);
        end
        run_block(40, 0, "zero_after_impulse");
    endtask

    task automatic test_flow_control();
        rand_bits(40);
        run_block(40, 1, "flow_control");
    endtask

    task automatic test_random_blocks();
        for (int r = 0; r < 3; r++) begin
            int k = $urandom_range(KMIN, 120);
            rand_bits(k);
            run_block(k, 0, "random_block");
        end
    endtask

    task automatic test_fifo_full();
        int tf;
        int n;
        rand_bits(DEPTH);
        fill_fifo();
        checks++;
        if (bus.fifo_used !== FW'(DEPTH) || bus.ck1_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: used %0d ready %b, want %0d and 0", bus.fifo_used,
                     bus.ck1_ready, DEPTH);
        end
        bus.ck1_valid = 1'b1;
        bus.ck1       = 1'b1;
        @(negedge clk);
        bus.ck1_valid = 1'b0;
        checks++;
        if (bus.fifo_used !== FW'(DEPTH)) begin
            errors++;
            $display("FAIL fifo_refuse: used %0d want %0d", bus.fifo_used, DEPTH);
        end
        got_q.delete();
        got_t.delete();
        mon_en      = 1'b1;
        bus.start   = 1'b1;
        bus.blk_len = KW'(DEPTH);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.ck2_valid = 1'b1;
        bus.ck2       = b2[0];
        @(negedge clk);
        checks++;
        if (bus.fifo_used !== FW'(DEPTH - 1) || bus.ck1_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_first_pop: used %0d ready %b, want %0d and 1", bus.fifo_used,
                     bus.ck1_ready, DEPTH - 1);
        end
        stream(DEPTH, 0, -1, 1);
        wait_idle(tf);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        build_expected(DEPTH);
        checks++;
        if (got_q.size() != DEPTH + 6) begin
            errors++;
            $display("FAIL fifo_block count: got %0d want %0d", got_q.size(), DEPTH + 6);
        end
        n = (got_q.size() < DEPTH + 6) ? got_q.size() : DEPTH + 6;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fifo_block tuple[%0d]: got %b want %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_errors();
        bus.start   = 1'b1;
        bus.blk_len = KW'(KMIN - 1);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.err_len !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL err_short: err %b busy %b, want 1 and 0", bus.err_len, bus.busy);
        end
        rand_bits(40);
        fill_fifo();
        got_q.delete();
        got_t.delete();
        mon_en      = 1'b1;
        bus.start   = 1'b1;
        bus.blk_len = KW'(40);
        @(negedge clk);
        checks++;
        if (bus.err_len !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err %b busy %b, want 0 and 1", bus.err_len, bus.busy);
        end
        bus.blk_len = KW'(KMIN - 1);
        stream(40, 0, 20, 0);
        bus.start = 1'b0;
        checks++;
        if (bus.err_len !== 1'b0) begin
            errors++;
            $display("FAIL err_busy_start: err %b want 0", bus.err_len);
        end
        aclr = 1'b1;
        @(negedge clk);
        aclr = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.fifo_used !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy %b used %0d, want 0 and 0", bus.busy, bus.fifo_used);
        end
        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (got_q.size() != 20 || got_q[got_q.size()-1][0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_tuples: got %0d tuples, want 20 without out_last", got_q.size());
        end
        bus.start   = 1'b1;
        bus.blk_len = KW'(KMAX + 1);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.err_len !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL err_long: err %b busy %b, want 1 and 0", bus.err_len, bus.busy);
        end
        rand_bits(KMIN);
        run_block(KMIN, 0, "after_errors");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        aclr          = 1'b1;
        bus.start     = 1'b0;
        bus.blk_len   = '0;
        bus.ck1       = 1'b0;
        bus.ck1_valid = 1'b0;
        bus.ck2       = 1'b0;
        bus.ck2_valid = 1'b0;
        repeat (2) @(negedge clk);
        aclr = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero_block();
        test_impulse();
        test_flow_control();
        test_random_blocks();
        test_fifo_full();
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
